ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that keeps a queue in an external single-port synchronous RAM
// and presents the oldest word through a one-entry output register.
module ram_fifo_ctrl #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [WIDTH-1:0]  push_data,
  output logic              push_ready,
  output logic              pop_valid,
  output logic [WIDTH-1:0]  pop_data,
  input  logic              pop_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              write_enb,
  output logic              read_enb,
  output logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out
);

  // Handshakes: a word moves on a rising edge where its valid and ready are
  // both 1; valid never depends on ready, and pop_data is stable while waiting.

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              out_valid_q, out_valid_d;
  logic              pri_q, pri_d;
  logic [WIDTH-1:0]  pop_data_q, pop_data_d;

  logic full_c;
  logic rd_req;
  logic wr_req;
  logic wr_gnt;
  logic rd_gnt;

  // Requests are gated by reset so no strobe or ready escapes while held in reset.
  always_comb begin
    full_c = (count_q == FULL_CNT);
    rd_req = reset && (count_q != '0) && !rd_inflight_q && (!out_valid_q || pop_ready);
    wr_req = reset && push_valid && !full_c;
    wr_gnt = wr_req && (!rd_req || !pri_q);
    rd_gnt = rd_req && (!wr_req || pri_q);
  end

  always_comb begin
    push_ready = reset && !full_c && (!rd_req || !pri_q);
    pop_valid  = out_valid_q;
    pop_data   = pop_data_q;
    count      = count_q;
    full       = full_c;
    empty      = (count_q == '0) && !rd_inflight_q && !out_valid_q;
    write_enb  = wr_gnt;
    read_enb   = rd_gnt;
    address    = '0;
    data_in    = '0;
    if (wr_gnt) begin
      address = wr_ptr_q;
      data_in = push_data;
    end else if (rd_gnt) begin
      address = rd_ptr_q;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_inflight_d = rd_inflight_q;
    out_valid_d   = out_valid_q;
    pri_d         = pri_q;
    pop_data_d    = pop_data_q;
    if (wr_gnt) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end
    if (rd_gnt) begin
      rd_ptr_d      = rd_ptr_q + PTR_ONE;
      count_d       = count_q - CNT_ONE;
      rd_inflight_d = 1'b1;
    end
    // A read can only issue with nothing in flight, so capture and issue never collide.
    if (rd_inflight_q) begin
      pop_data_d    = data_out;
      out_valid_d   = 1'b1;
      rd_inflight_d = 1'b0;
    end else if (out_valid_q && pop_ready) begin
      out_valid_d = 1'b0;
    end
    // On a conflict the priority flips toward whichever side just lost.
    if (wr_req && rd_req) begin
      pri_d = ~pri_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      pri_q         <= 1'b0;
      pop_data_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_inflight_q <= rd_inflight_d;
      out_valid_q   <= out_valid_d;
      pri_q         <= pri_d;
      pop_data_q    <= pop_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-level model of the FIFO and its RAM.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              push_valid;
  logic [WIDTH-1:0]  push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [WIDTH-1:0]  pop_data;
  logic              pop_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              write_enb;
  logic              read_enb;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;

  int checks;
  int errors;

  ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty),
    .write_enb(write_enb), .read_enb(read_enb), .address(address),
    .data_in(data_in), .data_out(data_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // synchronous single-port RAM: read data valid one edge after read_enb is sampled
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (write_enb) mem[address] <= data_in;
    if (read_enb) data_out <= mem[address];
  end

  // reference model: words resident in RAM, one word in flight, one in the output slot
  logic [WIDTH-1:0] ram_q [$];
  logic [WIDTH-1:0] exp_q [$];
  bit               m_inf, m_ov, m_pri;
  logic [WIDTH-1:0] m_inf_word, m_pop_word, sb_word;
  int               m_wr, m_rd, cnt;
  bit               e_rd_req, e_wr_req, e_wg, e_rg, e_pr;
  logic [ADDR_W-1:0] e_addr;
  logic [WIDTH-1:0]  e_din;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ({count, full, empty, pop_valid, push_ready, write_enb, read_enb, address, data_in, pop_data}
          !== {6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 8'd0}) begin
        errors++;
        $display("FAIL mon_reset t=%0t got cnt=%0d full=%b empty=%b pv=%b pr=%b we=%b re=%b a=%0d din=%h pd=%h",
                 $time, count, full, empty, pop_valid, push_ready, write_enb, read_enb, address, data_in, pop_data);
      end
      ram_q.delete(); exp_q.delete();
      m_inf = 0; m_ov = 0; m_pri = 0; m_pop_word = '0; m_wr = 0; m_rd = 0;
    end else begin
      cnt      = ram_q.size();
      e_rd_req = (cnt != 0) && !m_inf && (!m_ov || pop_ready);
      e_wr_req = push_valid && (cnt != DEPTH);
      e_wg     = e_wr_req && (!e_rd_req || !m_pri);
      e_rg     = e_rd_req && !e_wg;
      e_pr     = (cnt != DEPTH) && (!e_rd_req || !m_pri);
      e_addr   = e_wg ? 5'(m_wr % DEPTH) : (e_rg ? 5'(m_rd % DEPTH) : 5'd0);
      e_din    = e_wg ? push_data : 8'd0;
      checks++;
      if ({count, full, empty, pop_valid, push_ready}
          !== {6'(cnt), cnt == DEPTH, (cnt == 0) && !m_inf && !m_ov, m_ov, e_pr}) begin
        errors++;
        $display("FAIL mon_status t=%0t got cnt=%0d full=%b empty=%b pv=%b pr=%b exp cnt=%0d full=%b empty=%b pv=%b pr=%b",
                 $time, count, full, empty, pop_valid, push_ready, cnt, cnt == DEPTH,
                 (cnt == 0) && !m_inf && !m_ov, m_ov, e_pr);
      end
      checks++;
      if ({write_enb, read_enb, address, data_in} !== {e_wg, e_rg, e_addr, e_din}) begin
        errors++;
        $display("FAIL mon_ram t=%0t got we=%b re=%b a=%0d din=%h exp we=%b re=%b a=%0d din=%h",
                 $time, write_enb, read_enb, address, data_in, e_wg, e_rg, e_addr, e_din);
      end
      checks++;
      if (pop_data !== m_pop_word) begin
        errors++;
        $display("FAIL mon_pop_data t=%0t got %h exp %h", $time, pop_data, m_pop_word);
      end
      // scoreboard: every consumed word must be the oldest accepted word
      if (m_ov && pop_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop t=%0t got %h exp <nothing queued>", $time, pop_data);
        end else begin
          sb_word = exp_q.pop_front();
          if (pop_data !== sb_word) begin
            errors++;
            $display("FAIL sb_pop t=%0t got %h exp %h", $time, pop_data, sb_word);
          end
        end
      end
      if (m_inf) begin
        m_pop_word = m_inf_word; m_ov = 1; m_inf = 0;
      end else if (m_ov && pop_ready) begin
        m_ov = 0;
      end
      if (e_wg) begin
        ram_q.push_back(push_data); exp_q.push_back(push_data); m_wr++;
      end
      if (e_rg) begin
        m_inf_word = ram_q.pop_front(); m_inf = 1; m_rd++;
      end
      if (e_wr_req && e_rd_req) m_pri = !m_pri;
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; push_valid = 1'b1; push_data = 8'h77; pop_ready = 1'b1;
    #2;
    checks++;
    if ({count, empty, full, push_ready, pop_valid, write_enb, read_enb, address, data_in}
        !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d empty=%b full=%b pr=%b pv=%b we=%b re=%b a=%0d din=%h exp idle reset values",
               count, empty, full, push_ready, pop_valid, write_enb, read_enb, address, data_in);
    end
    tick(); tick();
    reset = 1'b1; push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 6'd0) begin
      errors++;
      $display("FAIL reset_release got empty=%b cnt=%0d exp empty=1 cnt=0", empty, count);
    end
    tick();
  endtask

  task automatic test_latency();
    push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
    #1;
    checks++;
    if ({write_enb, read_enb, address, data_in} !== {1'b1, 1'b0, 5'd0, 8'hA5}) begin
      errors++;
      $display("FAIL lat_write got we=%b re=%b a=%0d din=%h exp we=1 re=0 a=0 din=a5", write_enb, read_enb, address, data_in);
    end
    tick();
    push_valid = 1'b0;
    #1;
    checks++;
    if ({read_enb, write_enb, address, pop_valid, count} !== {1'b1, 1'b0, 5'd0, 1'b0, 6'd1}) begin
      errors++;
      $display("FAIL lat_read got re=%b we=%b a=%0d pv=%b cnt=%0d exp re=1 we=0 a=0 pv=0 cnt=1", read_enb, write_enb, address, pop_valid, count);
    end
    tick();
    checks++;
    if (pop_valid !== 1'b0 || count !== 6'd0) begin
      errors++;
      $display("FAIL lat_edge2 got pv=%b cnt=%0d exp pv=0 cnt=0", pop_valid, count);
    end
    tick();
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || empty !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge3 got pv=%b pd=%h empty=%b exp pv=1 pd=a5 empty=0", pop_valid, pop_data, empty);
    end
    tick();
    checks++;
    if (pop_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL lat_after_pop got pv=%b empty=%b exp pv=0 empty=1", pop_valid, empty);
    end
  endtask

  task automatic test_fill_hold_drain();
    int acc = 0;
    int guard = 0;
    int popped = 0;
    pop_ready = 1'b0;
    while (full !== 1'b1 && guard < 200) begin
      push_valid = 1'b1; push_data = 8'(acc);
      #1;
      if (push_ready === 1'b1) acc++;
      tick();
      guard++;
    end
    push_valid = 1'b0;
    #1;
    // one word sits in the output slot, so the RAM fills after DEPTH+1 accepted pushes
    checks++;
    if (count !== 6'd32 || full !== 1'b1 || acc != 33 || pop_valid !== 1'b1 || pop_data !== 8'h00) begin
      errors++;
      $display("FAIL fill got cnt=%0d full=%b accepted=%0d pv=%b pd=%h exp cnt=32 full=1 accepted=33 pv=1 pd=00",
               count, full, acc, pop_valid, pop_data);
    end
    push_valid = 1'b1; push_data = 8'hFF;
    #1;
    checks++;
    if (push_ready !== 1'b0 || write_enb !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse got pr=%b we=%b exp pr=0 we=0", push_ready, write_enb);
    end
    tick(); tick(); tick();
    push_valid = 1'b0;
    checks++;
    if (count !== 6'd32) begin
      errors++;
      $display("FAIL full_no_change got cnt=%0d exp 32", count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== 8'h00 || read_enb !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle=%0d got pv=%b pd=%h re=%b exp pv=1 pd=00 re=0", i, pop_valid, pop_data, read_enb);
      end
    end
    pop_ready = 1'b1;
    guard = 0;
    while (empty !== 1'b1 && guard < 300) begin
      if (pop_valid === 1'b1) begin
        checks++;
        if (pop_data !== 8'(popped)) begin
          errors++;
          $display("FAIL drain_order got %h exp %h", pop_data, 8'(popped));
        end
        popped++;
      end
      tick();
      guard++;
    end
    checks++;
    if (popped != 33 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_count got popped=%0d empty=%b exp popped=33 empty=1", popped, empty);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    for (int i = 0; i < 400; i++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = 8'($urandom);
      pop_ready  = ($urandom_range(0, 3) != 0);
      #1;
      if (write_enb === 1'b1 && read_enb === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL b2b_exclusive cycle=%0d got we=1 re=1 exp at most one", i);
      end
      tick();
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    while (empty !== 1'b1 && guard < 300) begin
      tick();
      guard++;
    end
    checks++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got empty=%b left=%0d exp empty=1 left=0", empty, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int acc = 0;
    int pops = 0;
    int guard = 0;
    int last_wa = -1;
    bit wrapped = 0;
    pop_ready = 1'b1;
    while (pops < 40 && guard < 500) begin
      push_valid = (acc < 40);
      push_data  = 8'(8'h40 + acc);
      #1;
      if (write_enb === 1'b1) begin
        if (last_wa >= 0) begin
          checks++;
          if (int'(address) != (last_wa + 1) % DEPTH) begin
            errors++;
            $display("FAIL wrap_addr got %0d exp %0d", address, (last_wa + 1) % DEPTH);
          end
          if (last_wa == DEPTH - 1 && address == 5'd0) wrapped = 1;
        end
        last_wa = int'(address);
      end
      if (push_valid && push_ready === 1'b1) acc++;
      if (pop_valid === 1'b1) begin
        checks++;
        if (pop_data !== 8'(8'h40 + pops)) begin
          errors++;
          $display("FAIL wrap_order got %h exp %h", pop_data, 8'(8'h40 + pops));
        end
        pops++;
      end
      tick();
      guard++;
    end
    push_valid = 1'b0;
    checks++;
    if (!wrapped || pops != 40) begin
      errors++;
      $display("FAIL wrap_done got wrapped=%0d pops=%0d exp wrapped=1 pops=40", wrapped, pops);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int i = 0;
    pop_ready = 1'b0;
    while (count !== 6'd6 && guard < 50) begin
      push_valid = 1'b1; push_data = 8'(8'h90 + i);
      #1;
      if (push_ready === 1'b1) i++;
      tick();
      guard++;
    end
    push_valid = 1'b0;
    #1;
    checks++;
    if (count !== 6'd6 || pop_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got cnt=%0d pv=%b exp cnt=6 pv=1", count, pop_valid);
    end
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    #1;
    checks++;
    if (count !== 6'd5) begin
      errors++;
      $display("FAIL mid_inflight got cnt=%0d exp 5", count);
    end
    reset = 1'b0; push_valid = 1'b1; push_data = 8'h11; pop_ready = 1'b1;
    #1;
    checks++;
    if ({count, empty, full, push_ready, pop_valid, pop_data, write_enb, read_enb, address, data_in}
        !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d empty=%b full=%b pr=%b pv=%b pd=%h we=%b re=%b a=%0d din=%h exp reset values",
               count, empty, full, push_ready, pop_valid, pop_data, write_enb, read_enb, address, data_in);
    end
    tick(); tick();
    reset = 1'b1; push_valid = 1'b0;
    tick();
    push_valid = 1'b1; push_data = 8'h3C; pop_ready = 1'b1;
    tick();
    push_valid = 1'b0;
    guard = 0;
    while (pop_valid !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 8'h3C) begin
      errors++;
      $display("FAIL mid_after got pv=%b pd=%h exp pv=1 pd=3c", pop_valid, pop_data);
    end
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_empty got empty=%b exp 1", empty);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    test_reset();
    test_latency();
    test_fill_hold_drain();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
